// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between fetch (port 0) and data (port 1).
// Grant -> ADDR -> ACCESS -> DONE: ack three cycles after the request is sampled; req is ignored while busy.
module ram_access_arbiter #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic            we0,
   input  logic [SIZE-1:0] addr0,
   input  logic [SIZE-1:0] wdata0,
   output logic            ack0,
   input  logic            req1,
   input  logic            we1,
   input  logic [SIZE-1:0] addr1,
   input  logic [SIZE-1:0] wdata1,
   output logic            ack1,
   output logic [SIZE-1:0] rdata,
   output logic            busy,
   output logic [SIZE-1:0] ram_address,
   output logic            ram_set_address,
   output logic            ram_set,
   output logic            ram_enable,
   output logic [SIZE-1:0] ram_data_in,
   input  logic [SIZE-1:0] ram_data_out
);

   typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

   state_t          state_q, state_d;
   logic            win_q, win_d;
   logic            we_q, we_d;
   logic            ptr_q, ptr_d;
   logic [SIZE-1:0] addr_q, addr_d;
   logic [SIZE-1:0] wdata_q, wdata_d;
   logic [SIZE-1:0] rdata_q, rdata_d;
   logic            grant1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         ptr_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         we_q    <= we_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Port 1 wins when it is the only requester, or on a tie when the pointer names it.
   assign grant1 = req1 & (~req0 | ptr_q);

   always_comb begin
      state_d         = state_q;
      win_d           = win_q;
      we_d            = we_q;
      ptr_d           = ptr_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      rdata_d         = rdata_q;
      ack0            = 1'b0;
      ack1            = 1'b0;
      ram_address     = '0;
      ram_set_address = 1'b0;
      ram_set         = 1'b0;
      ram_enable      = 1'b0;
      ram_data_in     = '0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               win_d   = grant1;
               we_d    = grant1 ? we1    : we0;
               addr_d  = grant1 ? addr1  : addr0;
               wdata_d = grant1 ? wdata1 : wdata0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            ram_address     = addr_q;
            ram_set_address = 1'b1;
            state_d         = ACCESS;
         end
         ACCESS: begin
            ram_address = addr_q;
            ram_data_in = wdata_q;
            ram_set     = we_q;
            ram_enable  = ~we_q;
            if (!we_q) begin
               rdata_d = ram_data_out;
            end
            state_d = DONE;
         end
         DONE: begin
            ack0    = ~win_q;
            ack1    = win_q;
            ptr_d   = ~win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rdata = rdata_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: behavioural RAM, scoreboard of expected accesses,
// table of single-port accesses plus contention, back-to-back and mid-access reset sequences.
module tb_ram_access_arbiter;

   typedef struct {
      int         port;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } xact_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       ack0, ack1, busy;
   logic [7:0] rdata, ram_address, ram_data_in, ram_data_out;
   logic       ram_set_address, ram_set, ram_enable;

   int         n_cmp = 0;
   int         n_fail = 0;
   xact_t      sb[$];
   int         ptr_model;
   logic [7:0] last_rdata;

   logic [7:0] mem [256];
   logic [7:0] mar;

   always #5 clk = ~clk;

   ram_access_arbiter #(.SIZE(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .ram_address(ram_address), .ram_set_address(ram_set_address),
      .ram_set(ram_set), .ram_enable(ram_enable),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // RAM with a memory address register loaded by set_address.
   always @(posedge clk) begin
      if (ram_set_address) mar <= ram_address;
      if (ram_set) mem[mar] <= ram_data_in;
   end
   assign ram_data_out = ram_enable ? mem[mar] : 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] all_out();
      return {2'b00, busy, ack0, ack1, ram_set_address, ram_set, ram_enable,
              ram_address, ram_data_in, rdata};
   endfunction

   function automatic logic ack_of(input int p);
      return (p == 0) ? ack0 : ack1;
   endfunction

   task automatic drive(input xact_t t, input logic on);
      if (t.port == 0) begin
         req0 = on; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
      end else begin
         req1 = on; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
      end
   endtask

   task automatic monitor();
      logic  prev_sa, prev_st;
      xact_t cur;
      prev_sa = 1'b0;
      prev_st = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_sa = 1'b0; prev_st = 1'b0;
            sb.delete();
            ptr_model = 0;
            last_rdata = 8'h00;
         end else begin
            if (ram_set_address | ram_set | ram_enable | ack0 | ack1) begin
               chk("sb_has_entry", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  cur = sb[0];
                  if (ram_set_address) begin
                     chk("sa_addr", ram_address, cur.addr);
                     chk("sa_single", prev_sa, 0);
                  end
                  if (ram_set | ram_enable) begin
                     chk("strobe_excl", ram_set & ram_enable, 0);
                     chk("strobe_dir", ram_set, cur.we);
                     chk("strobe_addr", ram_address, cur.addr);
                     chk("strobe_after_sa", prev_sa, 1);
                     if (ram_set) chk("wr_data", ram_data_in, cur.wdata);
                  end
                  if (ack0 | ack1) begin
                     chk("ack_port", {ack1, ack0}, (cur.port == 1) ? 2'b10 : 2'b01);
                     chk("ack_after_strobe", prev_st, 1);
                     if (!cur.we) last_rdata = cur.rdata;
                     chk("rdata", rdata, last_rdata);
                     ptr_model = (cur.port == 0) ? 1 : 0;
                     void'(sb.pop_front());
                  end
               end
            end
            prev_sa = ram_set_address;
            prev_st = ram_set | ram_enable;
         end
      end
   endtask

   task automatic do_access(input xact_t t);
      int cyc;
      @(negedge clk);
      sb.push_back(t);
      drive(t, 1'b1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!ack_of(t.port) && cyc < 12);
      chk("ack_latency", cyc, 3);
      drive(t, 1'b0);
   endtask

   task automatic contend(input xact_t a, input xact_t b);
      int cyc;
      int first;
      @(negedge clk);
      first = ptr_model;
      if (first == 0) begin sb.push_back(a); sb.push_back(b); end
      else            begin sb.push_back(b); sb.push_back(a); end
      drive(a, 1'b1);
      drive(b, 1'b1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!(ack0 | ack1) && cyc < 12);
      chk("contend_first_lat", cyc, 3);
      chk("contend_first_port", ack1, first);
      if (ack1) drive(b, 1'b0); else drive(a, 1'b0);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!(ack0 | ack1) && cyc < 12);
      chk("contend_second_lat", cyc, 4);
      drive(a, 1'b0);
      drive(b, 1'b0);
   endtask

   xact_t vec [8];

   initial begin
      xact_t t;
      int    cyc;

      vec[0] = '{1, 1'b1, 8'h3C, 8'hA5, 8'h00};
      vec[1] = '{1, 1'b0, 8'h3C, 8'h00, 8'hA5};
      vec[2] = '{0, 1'b1, 8'h00, 8'h11, 8'h00};
      vec[3] = '{1, 1'b1, 8'hFF, 8'hEE, 8'h00};
      vec[4] = '{0, 1'b0, 8'h00, 8'h00, 8'h11};
      vec[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'hEE};
      vec[6] = '{0, 1'b1, 8'h10, 8'h77, 8'h00};
      vec[7] = '{0, 1'b0, 8'h3C, 8'h00, 8'hA5};

      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      fork monitor(); join_none

      #1 chk("reset_outputs", all_out(), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("idle_quiet", all_out(), 0);
      end

      // Simultaneous requests: the pointer model picks the first winner.
      contend('{0, 1'b1, 8'h20, 8'h5A, 8'h00}, '{1, 1'b1, 8'h21, 8'h6B, 8'h00});
      contend('{0, 1'b0, 8'h20, 8'h00, 8'h5A}, '{1, 1'b0, 8'h21, 8'h00, 8'h6B});

      for (int i = 0; i < 8; i++) do_access(vec[i]);

      // Last table entry was port 0, so port 1 should win this tie.
      contend('{0, 1'b1, 8'h30, 8'hC3, 8'h00}, '{1, 1'b0, 8'h21, 8'h00, 8'h6B});

      // Back-to-back on port 0 with req held across ack.
      t = '{0, 1'b0, 8'h10, 8'h00, 8'h77};
      @(negedge clk);
      sb.push_back(t);
      sb.push_back(t);
      drive(t, 1'b1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!ack0 && cyc < 12);
      chk("b2b_first_lat", cyc, 3);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("b2b_idle_gap", busy, 0);
         if (cyc == 2) chk("b2b_regrant", busy, 1);
      end while (!ack0 && cyc < 12);
      chk("b2b_second_lat", cyc, 4);
      drive(t, 1'b0);

      // Reset in the ACCESS cycle of a read.
      t = '{1, 1'b0, 8'h10, 8'h00, 8'h77};
      @(negedge clk);
      sb.push_back(t);
      drive(t, 1'b1);
      repeat (2) @(negedge clk);
      chk("mid_in_access", ram_enable, 1);
      #2 rst = 1'b1;
      #1 chk("mid_async_clear", all_out(), 0);
      drive(t, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_reset_hold", all_out(), 0);
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("mid_no_ack", {ack1, ack0}, 0);
      end
      do_access(t);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
